pixel_write_master: RTL and testbench
=====================================

Name: pixel_write_master

Overview:
- Downstream of the pixel output stage. Consumes per-pixel {pixel_data, byteenable} plus the pixel index, and buffers them in a small FIFO.
- Issues Avalon-MM write transfers to frame-buffer memory, honouring waitrequest.
- Decouples the rasterizer/output stage from memory stalls.
- Exposes ready/valid upstream and an idle flag for frame-done detection.

Parameters:
- IDX_W, 19, width of pixel index (covers 640x480 = 307200 pixels).
- ADDR_W, 32, Avalon byte-address width.
- BASE_ADDR, 32'h0000_0000, frame-buffer byte base address.
- FIFO_DEPTH, 4, number of buffered write entries; power of 2, >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- pixel_valid  in  1  upstream has a pixel this cycle.
- pixel_ready  out  1  block can accept a pixel this cycle.
- pixel_index  in  IDX_W  linear pixel index; bit 0 matches the output stage's address_lsb.
- pixel_data  in  32  {color,color} from the output stage.
- byteenable  in  4  4'b0011 (even pixel) or 4'b1100 (odd pixel).
- avm_address  out  ADDR_W  byte address of write.
- avm_write  out  1  write request.
- avm_writedata  out  32  write data.
- avm_byteenable  out  4  byte lanes.
- avm_waitrequest  in  1  slave stall.
- idle  out  1  FIFO empty and no transfer outstanding.

Behaviour:
- Reset (sync, rst=1 at clk edge) clears FIFO count/pointers; next cycle avm_write=0, avm_address=0, avm_writedata=0, avm_byteenable=0, idle=1, pixel_ready=1. Reset mid-transfer abandons buffered entries; the in-flight write drops with no completion.
- Address: entry byte address = BASE_ADDR + {pixel_index[IDX_W-1:1], 2'b00}, computed at push, ADDR_W-wide, truncating on overflow.
- Push: pixel_valid && pixel_ready. pixel_ready = (count != FIFO_DEPTH), combinational from registered count.
- FIFO is registered storage of {address, data, byteenable}. avm_* outputs are driven directly from the head entry.
- avm_write = (count != 0). No combinational path from pixel_valid to avm_write, so push-to-first-write latency is 1 cycle.
- Pop: avm_write && !avm_waitrequest. While waitrequest=1, avm_address/writedata/byteenable/write stay stable (Avalon rule).
- Simultaneous push and pop: allowed at any count < FIFO_DEPTH; count unchanged. When full, push is blocked even if a pop happens in the same cycle.
- Pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.
- idle = (count == 0), registered-derived.
- Sustained throughput: 1 write/cycle when waitrequest=0.
- pixel_valid while pixel_ready=0: ignored; upstream must hold.
- FSM: IDLE (count=0) -> ACTIVE (count>0) on push. ACTIVE -> IDLE when the final pop occurs with no simultaneous push. FULL is a substate of ACTIVE with pixel_ready=0.

Optional Feature:
- Macro PWM_COALESCE_EN.
- Defined: on push with count >= 2 (tail is not the head being presented) and the new word address equal to the tail entry's address, merge into the tail instead of allocating.
  - Tail byteenable |= new byteenable; bytes in new byteenable lanes are overwritten with new data.
  - count is unchanged by the push, but still decrements on a simultaneous pop.
  - pixel_ready is unchanged: still requires count != FIFO_DEPTH.
- Undefined: every push allocates a new entry; no merge logic is synthesized.

Test Plan:
- Reset then single push (index 5, data 32'hF800F800, be 4'b1100, waitrequest=0) -> next cycle avm_write=1, avm_address=BASE+8, avm_byteenable=4'b1100. Following cycle idle=1.
- waitrequest held 1 for 3 cycles with entry presented -> avm_* stable all 3 cycles; pop on cycle 4; exactly one write observed.
- Push 5 pixels back-to-back with waitrequest=1 (FIFO_DEPTH=4) -> pixel_ready=0 after 4th push. Release waitrequest -> 4 writes in order, then 5th accepted and written.
- Continuous push with waitrequest=0 -> one write per cycle, indices 0..7 map to addresses 0,0,4,4,8,8,12,12.
- Assert rst while 3 entries buffered and waitrequest=1 -> next cycle avm_write=0, idle=1, no further writes.
- PWM_COALESCE_EN, waitrequest=1: push idx 2, 10, 11 -> count=2. idx 11 merged into idx 10's entry, giving byteenable 4'b1111 at BASE+20 with the upper half from idx 11's data. Without the macro: count=3.

Source files
------------

// File: rtl/pixel_write_master.sv
// Buffers per-pixel writes in a small FIFO and drains them as Avalon-MM writes.
// Optional macro PWM_COALESCE_EN merges a push into the tail entry when both hit the same word.
module pixel_write_master #(
  parameter int                IDX_W      = 19,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pixel_valid,
  output logic              pixel_ready,
  input  logic [IDX_W-1:0]  pixel_index,
  input  logic [31:0]       pixel_data,
  input  logic [3:0]        byteenable,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  output logic              idle
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_FULL
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;

  logic [ADDR_W-1:0] addr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] addr_d [FIFO_DEPTH];
  logic [31:0]       data_q [FIFO_DEPTH];
  logic [31:0]       data_d [FIFO_DEPTH];
  logic [3:0]        be_q   [FIFO_DEPTH];
  logic [3:0]        be_d   [FIFO_DEPTH];

  logic              push;
  logic              pop;
  logic              alloc;
  logic [IDX_W:0]    word_off;
  logic [ADDR_W-1:0] push_addr;
`ifdef PWM_COALESCE_EN
  logic              merge;
  logic [PTR_W-1:0]  tail_ptr;
`endif

  always_comb begin
    push = pixel_valid && (state_q != ST_FULL);
    pop  = (state_q != ST_IDLE) && !avm_waitrequest;

    // {index, 0} with the low two bits cleared is the word-aligned byte offset of the pixel pair
    word_off  = {pixel_index, 1'b0} & ~((IDX_W+1)'(3));
    push_addr = BASE_ADDR + ADDR_W'(word_off);

    addr_d   = addr_q;
    data_d   = data_q;
    be_d     = be_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

`ifdef PWM_COALESCE_EN
    tail_ptr = wr_ptr_q - PTR_W'(1);
    merge    = push && (count_q >= CNT_W'(2)) && (addr_q[tail_ptr] == push_addr);
    alloc    = push && !merge;
    if (merge) begin
      be_d[tail_ptr] = be_q[tail_ptr] | byteenable;
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) data_d[tail_ptr][8*b +: 8] = pixel_data[8*b +: 8];
      end
    end
`else
    alloc = push;
`endif

    if (alloc) begin
      addr_d[wr_ptr_q] = push_addr;
      data_d[wr_ptr_q] = pixel_data;
      be_d[wr_ptr_q]   = byteenable;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({alloc, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (count_d == '0)          state_d = ST_IDLE;
    else if (count_d == DEPTH_C) state_d = ST_FULL;
    else                         state_d = ST_ACTIVE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage needs no reset: it is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    be_q   <= be_d;
  end

  assign avm_write      = (state_q != ST_IDLE);
  assign pixel_ready    = (state_q != ST_FULL);
  assign idle           = (state_q == ST_IDLE);
  assign avm_address    = avm_write ? addr_q[rd_ptr_q] : '0;
  assign avm_writedata  = avm_write ? data_q[rd_ptr_q] : '0;
  assign avm_byteenable = avm_write ? be_q[rd_ptr_q]   : '0;

endmodule

// File: tb/tb_pixel_write_master.sv
// Directed bench for pixel_write_master: vector table plus stall/full/reset/merge sequences.
module tb_pixel_write_master;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        pixel_valid;
  logic        pixel_ready;
  logic [18:0] pixel_index;
  logic [31:0] pixel_data;
  logic [3:0]  byteenable;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic        idle;

  pixel_write_master #(
    .IDX_W(19), .ADDR_W(32), .BASE_ADDR(BASE), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .pixel_index(pixel_index), .pixel_data(pixel_data), .byteenable(byteenable),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  typedef struct {
    logic        valid;
    logic [18:0] idx;
    logic [31:0] data;
    logic [3:0]  be;
    logic        wr;
    logic        exp_write;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic [3:0]  exp_be;
    logic        exp_ready;
    logic        exp_idle;
  } vec_t;

  wr_t  exp_q[$];
  wr_t  obs_q[$];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [31:0] pix_data(int k);
    return 32'hD000_0000 + k * 32'h0101;
  endfunction

  function automatic logic [3:0] pix_be(int k);
    return (k % 2 == 1) ? 4'b1100 : 4'b0011;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [18:0] i, input logic [31:0] d,
                      input logic [3:0] b, input logic w);
    @(negedge clk);
    pixel_valid     = v;
    pixel_index     = i;
    pixel_data      = d;
    byteenable      = b;
    avm_waitrequest = w;
    #1;
    if (v && pixel_ready) exp_q.push_back('{BASE + {11'd0, i[18:1], 2'b00}, d, b});
    if (avm_write && !avm_waitrequest) obs_q.push_back('{avm_address, avm_writedata, avm_byteenable});
  endtask

  task automatic idle_step();
    step(1'b0, 19'd0, 32'd0, 4'd0, 1'b0);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (n < 20) begin
      idle_step();
      if (idle) break;
      n++;
    end
    check({name, "_drain_idle"}, 32'(idle), 32'd1);
  endtask

  task automatic compare_queues(input string name);
    check({name, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_addr%0d", name, i), obs_q[i].addr, exp_q[i].addr);
      check($sformatf("%s_data%0d", name, i), obs_q[i].data, exp_q[i].data);
      check($sformatf("%s_be%0d",   name, i), 32'(obs_q[i].be), 32'(exp_q[i].be));
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_write"}, 32'(avm_write), 32'd0);
    check({name, "_addr"},  avm_address, 32'd0);
    check({name, "_data"},  avm_writedata, 32'd0);
    check({name, "_be"},    32'(avm_byteenable), 32'd0);
    check({name, "_idle"},  32'(idle), 32'd1);
    check({name, "_ready"}, 32'(pixel_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int word_addr [8] = '{0, 0, 4, 4, 8, 8, 12, 12};

    // single pixel idx 5 -> BASE+8, then idle
    vecs.push_back('{1'b1, 19'd5, 32'hF800_F800, 4'b1100, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 19'd0, 32'd0, 4'd0, 1'b0, 1'b1, BASE + 32'd8, 32'hF800_F800, 4'b1100, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 19'd0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1});
    // streaming idx 0..7 with no stall: each row sees the previous pixel presented
    for (int k = 0; k < 9; k++) begin
      vec_t v;
      v.valid     = (k < 8);
      v.idx       = (k < 8) ? 19'(k) : 19'd0;
      v.data      = (k < 8) ? pix_data(k) : 32'd0;
      v.be        = (k < 8) ? pix_be(k) : 4'd0;
      v.wr        = 1'b0;
      v.exp_write = (k > 0);
      v.exp_addr  = (k > 0) ? BASE + 32'(word_addr[k-1]) : 32'd0;
      v.exp_data  = (k > 0) ? pix_data(k-1) : 32'd0;
      v.exp_be    = (k > 0) ? pix_be(k-1) : 4'd0;
      v.exp_ready = 1'b1;
      v.exp_idle  = (k == 0);
      vecs.push_back(v);
    end
    vecs.push_back('{1'b0, 19'd0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1});

    rst = 1'b1; pixel_valid = 1'b0; pixel_index = '0; pixel_data = '0;
    byteenable = '0; avm_waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("reset");

    foreach (vecs[r]) begin
      step(vecs[r].valid, vecs[r].idx, vecs[r].data, vecs[r].be, vecs[r].wr);
      check($sformatf("vec%0d_write", r), 32'(avm_write), 32'(vecs[r].exp_write));
      check($sformatf("vec%0d_ready", r), 32'(pixel_ready), 32'(vecs[r].exp_ready));
      check($sformatf("vec%0d_idle", r),  32'(idle), 32'(vecs[r].exp_idle));
      if (vecs[r].exp_write) begin
        check($sformatf("vec%0d_addr", r), avm_address, vecs[r].exp_addr);
        check($sformatf("vec%0d_data", r), avm_writedata, vecs[r].exp_data);
        check($sformatf("vec%0d_be", r),   32'(avm_byteenable), 32'(vecs[r].exp_be));
      end
    end
    compare_queues("table");

    // waitrequest stall: presented entry stays stable, exactly one write
    step(1'b1, 19'd6, 32'h0707_0707, 4'b0011, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 19'd0, 32'd0, 4'd0, 1'b1);
      check($sformatf("stall%0d_write", c), 32'(avm_write), 32'd1);
      check($sformatf("stall%0d_addr", c),  avm_address, BASE + 32'd12);
      check($sformatf("stall%0d_data", c),  avm_writedata, 32'h0707_0707);
      check($sformatf("stall%0d_be", c),    32'(avm_byteenable), 32'b0011);
    end
    idle_step();
    check("stall_release_write", 32'(avm_write), 32'd1);
    idle_step();
    check("stall_after_idle", 32'(idle), 32'd1);
    compare_queues("stall");

    // fill to FIFO_DEPTH under stall, 5th pixel held until space frees
    for (int k = 20; k < 24; k++) step(1'b1, 19'(k), pix_data(k), pix_be(k), 1'b1);
    step(1'b1, 19'd24, pix_data(24), pix_be(24), 1'b1);
    check("full_ready", 32'(pixel_ready), 32'd0);
    step(1'b1, 19'd24, pix_data(24), pix_be(24), 1'b0);
    check("full_pop_ready", 32'(pixel_ready), 32'd0);
    step(1'b1, 19'd24, pix_data(24), pix_be(24), 1'b0);
    check("after_pop_ready", 32'(pixel_ready), 32'd1);
    drain("full");
    compare_queues("full");

    // reset with 3 buffered entries under stall
    for (int k = 30; k < 33; k++) step(1'b1, 19'(k), pix_data(k), pix_be(k), 1'b1);
    @(negedge clk);
    rst = 1'b1; pixel_valid = 1'b0; avm_waitrequest = 1'b1;
    @(negedge clk);
    rst = 1'b0; avm_waitrequest = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    obs_q.delete();
    repeat (4) idle_step();
    check("midreset_no_writes", obs_q.size(), 32'd0);

    // same-word pushes while stalled
    step(1'b1, 19'd2,  32'h5555_5555, 4'b0011, 1'b1);
    step(1'b1, 19'd10, 32'h1234_1234, 4'b0011, 1'b1);
    step(1'b1, 19'd11, 32'hABCD_ABCD, 4'b1100, 1'b1);
    exp_q.delete();
    idle_step();
    check("merge_e0_addr", avm_address, BASE + 32'd4);
    check("merge_e0_be",   32'(avm_byteenable), 32'b0011);
    idle_step();
    check("merge_e1_addr", avm_address, BASE + 32'd20);
`ifdef PWM_COALESCE_EN
    check("merge_e1_be",   32'(avm_byteenable), 32'b1111);
    check("merge_e1_data", avm_writedata, 32'hABCD_1234);
    idle_step();
    check("merge_done_idle", 32'(idle), 32'd1);
    check("merge_writes", obs_q.size(), 32'd2);
`else
    check("merge_e1_be",   32'(avm_byteenable), 32'b0011);
    check("merge_e1_data", avm_writedata, 32'h1234_1234);
    idle_step();
    check("merge_e2_addr", avm_address, BASE + 32'd20);
    check("merge_e2_be",   32'(avm_byteenable), 32'b1100);
    check("merge_e2_data", avm_writedata, 32'hABCD_ABCD);
    idle_step();
    check("merge_done_idle", 32'(idle), 32'd1);
    check("merge_writes", obs_q.size(), 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
